// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit.
//
// load_store_unit_req_if : core <-> unit request/response channel.
//   master = core control FSM, slave = load/store unit.
// load_store_unit_mem_if : unit <-> memory bus.
//   master = load/store unit, slave = memory.
//
// Handshake rules, shared by both bundles:
//   A request transfers on a rising edge where valid && ready are both high.
//   Once valid is raised, it and every payload field stay stable until that
//   edge. On the memory side ready may be held low for any number of cycles
//   (wait states). The response channel has no ready: resp_valid is a
//   one-cycle pulse that the core always takes.

interface load_store_unit_req_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [1:0]        resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface load_store_unit_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access (byte/half/word/double, signed or
// unsigned) into a single word-aligned memory bus transfer with byte strobes,
// then returns the extended load data or an error code.
//
// Ports
//   clk, resetn : clock (rising edge), asynchronous active-low reset
//   req         : core request/response channel (slave side)
//   mem         : memory bus (master side)
//   dbg_state   : current FSM state (0 IDLE, 1 BUS, 2 RESP)
//
// resp_err: 00 ok, 01 misaligned, 10 illegal size, 11 bus timeout.
// MAX_WAIT = 0 disables the bus timeout.

module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                         clk,
  input  logic                         resetn,
  load_store_unit_req_if.slave         req,
  load_store_unit_mem_if.master        mem,
  output logic [1:0]                   dbg_state
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  // Low during reset and until the first edge after release, so req_ready
  // never shows 1 while the unit is held in reset.
  logic              alive_q, alive_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic [OFF_W-1:0]  req_off;
  logic              size_illegal;
  logic              misaligned;
  logic [XLEN-1:0]   st_wdata;
  logic [NB-1:0]     st_wstrb;
  logic [XLEN-1:0]   ld_lane;
  logic [XLEN-1:0]   ld_data;

  // ---------------------------------------------------------------------
  // Request decode: legality, alignment and store lane formation.
  // ---------------------------------------------------------------------
  always_comb begin
    req_off      = req.req_addr[OFF_W-1:0];
    size_illegal = 1'b0;
    case (req.req_funct3)
      3'b011:         size_illegal = (XLEN == 32);
      3'b110:         size_illegal = (XLEN == 32) || req.req_write;
      3'b100, 3'b101: size_illegal = req.req_write;
      3'b111:         size_illegal = 1'b1;
      default:        size_illegal = 1'b0;
    endcase

    misaligned = 1'b0;
    case (req.req_funct3[1:0])
      2'b01:   misaligned = req.req_addr[0];
      2'b10:   misaligned = |req.req_addr[1:0];
      2'b11:   misaligned = |req.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase

    // Store data is replicated across every lane so the strobes alone pick
    // the bytes that land in memory.
    st_wdata = req.req_wdata;
    st_wstrb = '1;
    case (req.req_funct3[1:0])
      2'b00: begin
        st_wdata = {NB{req.req_wdata[7:0]}};
        st_wstrb = NB'(1) << req_off;
      end
      2'b01: begin
        st_wdata = {(NB/2){req.req_wdata[15:0]}};
        st_wstrb = NB'(2'b11) << req_off;
      end
      2'b10: begin
        st_wdata = {(NB/4){req.req_wdata[31:0]}};
        st_wstrb = NB'(4'hF) << req_off;
      end
      default: begin
        st_wdata = req.req_wdata;
        st_wstrb = '1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Load extraction: shift the addressed lane down, then extend.
  // ---------------------------------------------------------------------
  always_comb begin
    ld_lane = mem.mem_rdata >> {off_q, 3'b000};
    ld_data = ld_lane;
    case (funct3_q)
      3'b000:  ld_data = XLEN'($signed(ld_lane[7:0]));
      3'b100:  ld_data = XLEN'(ld_lane[7:0]);
      3'b001:  ld_data = XLEN'($signed(ld_lane[15:0]));
      3'b101:  ld_data = XLEN'(ld_lane[15:0]);
      3'b010:  ld_data = XLEN'($signed(ld_lane[31:0]));
      3'b110:  ld_data = XLEN'(ld_lane[31:0]);
      default: ld_data = ld_lane;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM next state and datapath registers.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    alive_d    = 1'b1;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (req.req_valid && alive_q) begin
          we_d     = req.req_write;
          funct3_d = req.req_funct3;
          off_d    = req_off;
          addr_d   = req.req_addr & ~ADDR_W'(NB - 1);
          wdata_d  = req.req_write ? st_wdata : '0;
          wstrb_d  = req.req_write ? st_wstrb : '0;
          rdata_d  = '0;
          // Illegal size outranks misalignment; neither touches the bus.
          if (size_illegal) begin
            err_d   = 2'b10;
            state_d = S_RESP;
          end else if (misaligned) begin
            err_d   = 2'b01;
            state_d = S_RESP;
          end else begin
            err_d   = 2'b00;
            state_d = S_BUS;
          end
        end
      end

      S_BUS: begin
        // A ready on the timeout cycle still counts as a normal completion.
        if (mem.mem_ready) begin
          rdata_d = we_q ? '0 : ld_data;
          err_d   = 2'b00;
          state_d = S_RESP;
        end else if ((MAX_WAIT != 0) && (wait_cnt_q == CNT_W'(MAX_WAIT - 1))) begin
          rdata_d = '0;
          err_d   = 2'b11;
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        wait_cnt_d = '0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      alive_q    <= 1'b0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      alive_q    <= alive_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: bus fields show only while BUS, response only while RESP.
  // ---------------------------------------------------------------------
  logic in_bus;
  logic in_resp;
  assign in_bus  = (state_q == S_BUS);
  assign in_resp = (state_q == S_RESP);

  assign req.req_ready  = alive_q && (state_q == S_IDLE);
  assign req.resp_valid = in_resp;
  assign req.resp_rdata = in_resp ? rdata_q : '0;
  assign req.resp_err   = in_resp ? err_q : 2'b00;

  assign mem.mem_valid  = in_bus;
  assign mem.mem_we     = in_bus && we_q;
  assign mem.mem_addr   = in_bus ? addr_q : '0;
  assign mem.mem_wdata  = in_bus ? wdata_q : '0;
  assign mem.mem_wstrb  = in_bus ? wstrb_q : '0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit unit (MAX_WAIT=4) and a 64-bit unit
// (MAX_WAIT=6) share stimulus; sel64 routes the request/bus to one of them
// and muxes its outputs onto 64-bit observation signals.

module tb_load_store_unit;

  localparam int MW32 = 4;
  localparam int MW64 = 6;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        sel64      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr   = '0;
  logic [63:0] req_wdata  = '0;
  logic        mem_ready  = 1'b0;
  logic [63:0] mem_rdata  = '0;

  int checks = 0;
  int errors = 0;

  load_store_unit_req_if #(.XLEN(32), .ADDR_W(32)) rq32 ();
  load_store_unit_mem_if #(.XLEN(32), .ADDR_W(32)) mm32 ();
  load_store_unit_req_if #(.XLEN(64), .ADDR_W(32)) rq64 ();
  load_store_unit_mem_if #(.XLEN(64), .ADDR_W(32)) mm64 ();

  assign rq32.req_valid  = req_valid & ~sel64;
  assign rq32.req_write  = req_write;
  assign rq32.req_funct3 = req_funct3;
  assign rq32.req_addr   = req_addr;
  assign rq32.req_wdata  = req_wdata[31:0];
  assign mm32.mem_ready  = mem_ready & ~sel64;
  assign mm32.mem_rdata  = mem_rdata[31:0];

  assign rq64.req_valid  = req_valid & sel64;
  assign rq64.req_write  = req_write;
  assign rq64.req_funct3 = req_funct3;
  assign rq64.req_addr   = req_addr;
  assign rq64.req_wdata  = req_wdata;
  assign mm64.mem_ready  = mem_ready & sel64;
  assign mm64.mem_rdata  = mem_rdata;

  logic [1:0] dbg32, dbg64;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW32)) u32 (
    .clk(clk), .resetn(resetn), .req(rq32), .mem(mm32), .dbg_state(dbg32)
  );
  load_store_unit #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(MW64)) u64 (
    .clk(clk), .resetn(resetn), .req(rq64), .mem(mm64), .dbg_state(dbg64)
  );

  // ---------------- observation mux ----------------
  logic        req_ready_o, resp_valid_o, mem_valid_o, mem_we_o;
  logic [63:0] resp_rdata_o, mem_wdata_o;
  logic [1:0]  resp_err_o, dbg_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wstrb_o;

  always_comb begin
    if (sel64) begin
      req_ready_o  = rq64.req_ready;
      resp_valid_o = rq64.resp_valid;
      resp_rdata_o = rq64.resp_rdata;
      resp_err_o   = rq64.resp_err;
      mem_valid_o  = mm64.mem_valid;
      mem_we_o     = mm64.mem_we;
      mem_addr_o   = mm64.mem_addr;
      mem_wdata_o  = mm64.mem_wdata;
      mem_wstrb_o  = mm64.mem_wstrb;
      dbg_o        = dbg64;
    end else begin
      req_ready_o  = rq32.req_ready;
      resp_valid_o = rq32.resp_valid;
      resp_rdata_o = {32'b0, rq32.resp_rdata};
      resp_err_o   = rq32.resp_err;
      mem_valid_o  = mm32.mem_valid;
      mem_we_o     = mm32.mem_we;
      mem_addr_o   = mm32.mem_addr;
      mem_wdata_o  = {32'b0, mm32.mem_wdata};
      mem_wstrb_o  = {4'b0, mm32.mem_wstrb};
      dbg_o        = dbg32;
    end
  end

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-level view: an access touches `size` consecutive bytes starting at
  // the lane offset; stores repeat the data pattern over every lane.
  function automatic void model(
    input  bit        is64, input bit wr, input bit [2:0] f3,
    input  bit [31:0] addr, input bit [63:0] wd, input bit [63:0] rd,
    input  int        waits,
    output bit [1:0]  xerr, output bit [63:0] xrd, output bit [31:0] xaddr,
    output bit [63:0] xwd,  output bit [7:0] xstrb);
    int lanes, size, off, maxw;
    bit legal;
    lanes = is64 ? 8 : 4;
    maxw  = is64 ? MW64 : MW32;
    size  = 1 << f3[1:0];
    off   = int'(addr % lanes);
    // Zero-extending loads only make sense when narrower than the register.
    legal = (size <= lanes) && !(f3[2] && (wr || size >= lanes));
    xrd = '0; xwd = '0; xstrb = '0;
    xaddr = addr - off;
    if (!legal)                            xerr = 2'b10;
    else if (addr % size != 0)             xerr = 2'b01;
    else if (maxw != 0 && waits >= maxw)   xerr = 2'b11;
    else                                   xerr = 2'b00;
    if (xerr == 2'b01 || xerr == 2'b10) return;
    if (wr) begin
      for (int i = 0; i < lanes; i++) begin
        xwd[8*i +: 8] = wd[8*(i % size) +: 8];
        if (i >= off && i < off + size) xstrb[i] = 1'b1;
      end
    end else if (xerr == 2'b00) begin
      for (int j = 0; j < size; j++) xrd[8*j +: 8] = rd[8*(off+j) +: 8];
      if (!f3[2] && size < lanes && xrd[8*size-1])
        for (int k = size; k < 8; k++) xrd[8*k +: 8] = 8'hFF;
      if (!is64) xrd[63:32] = '0;
    end
  endfunction

  // ---------------- driver: one full access ----------------
  task automatic run_access(
    input string name, input bit is64, input bit wr, input bit [2:0] f3,
    input bit [31:0] addr, input bit [63:0] wd, input bit [63:0] rd,
    input int waits, input bit [1:0] xerr, input bit [63:0] xrd,
    input bit [31:0] xaddr, input bit [63:0] xwd, input bit [7:0] xstrb);
    int guard, nbus, maxw;
    bit done;
    maxw  = is64 ? MW64 : MW32;
    sel64 = is64;
    #1;
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, " req_ready"}, 64'(req_ready_o), 64'd1);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (xerr == 2'b01 || xerr == 2'b10) begin
      check({name, " mem_valid_err"}, 64'(mem_valid_o), 64'd0);
    end else begin
      nbus = 0;
      done = 1'b0;
      while (!done) begin
        nbus++;
        check({name, " mem_valid"}, 64'(mem_valid_o), 64'd1);
        check({name, " mem_addr"},  64'(mem_addr_o),  64'(xaddr));
        check({name, " mem_we"},    64'(mem_we_o),    64'(wr));
        check({name, " mem_wstrb"}, 64'(mem_wstrb_o), 64'(xstrb));
        if (wr) check({name, " mem_wdata"}, mem_wdata_o, xwd);
        mem_ready = (nbus == waits + 1);
        mem_rdata = rd;
        done = mem_ready || (xerr == 2'b11 && nbus >= maxw) || nbus >= 300;
        @(negedge clk);
      end
      mem_ready = 1'b0;
      check({name, " mem_valid_drop"}, 64'(mem_valid_o), 64'd0);
    end
    check({name, " resp_valid"}, 64'(resp_valid_o), 64'd1);
    check({name, " resp_err"},   64'(resp_err_o),   64'(xerr));
    check({name, " resp_rdata"}, resp_rdata_o,      xrd);
    @(negedge clk);
    check({name, " resp_pulse"}, 64'(resp_valid_o), 64'd0);
    check({name, " rdata_idle"}, resp_rdata_o,      64'd0);
    check({name, " err_idle"},   64'(resp_err_o),   64'd0);
    check({name, " ready_back"}, 64'(req_ready_o),  64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit        is64; bit wr; bit [2:0] f3; bit [31:0] addr;
    bit [63:0] wd; bit [63:0] rd; int waits;
    bit [1:0]  xerr; bit [63:0] xrd; bit [31:0] xaddr; bit [63:0] xwd; bit [7:0] xstrb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    bit is64, bit wr, bit [2:0] f3, bit [31:0] addr, bit [63:0] wd, bit [63:0] rd,
    int waits, bit [1:0] xerr, bit [63:0] xrd, bit [31:0] xaddr, bit [63:0] xwd, bit [7:0] xstrb);
    vec_t v;
    v.is64 = is64; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
    v.waits = waits; v.xerr = xerr; v.xrd = xrd; v.xaddr = xaddr; v.xwd = xwd; v.xstrb = xstrb;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit [1:0]  m_err;
    bit [63:0] m_rd, m_wd, r_wd, r_rd;
    bit [31:0] m_addr, r_addr;
    bit [7:0]  m_strb;
    bit        r64, rwr;
    bit [2:0]  rf3;
    int        rwaits;

    //     is64 wr f3      addr      wdata                  rdata                  w  err   rdata                  addr      wdata                  strb
    vecs.push_back(mk(0, 0, 3'b000, 32'h103, 64'h0,               64'h80FF_1234,          0, 2'b00, 64'hFFFF_FF80,          32'h100, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 1, 3'b001, 32'h022, 64'h0000_ABCD,       64'h0,                  3, 2'b00, 64'h0,                  32'h020, 64'hABCD_ABCD,         8'h0C));
    vecs.push_back(mk(0, 0, 3'b010, 32'h006, 64'h0,               64'h0,                  0, 2'b01, 64'h0,                  32'h004, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 0, 3'b011, 32'h008, 64'h0,               64'h0,                  0, 2'b10, 64'h0,                  32'h008, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 0, 3'b010, 32'h040, 64'h0,               64'h1234_5678,          4, 2'b11, 64'h0,                  32'h040, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 0, 3'b010, 32'h040, 64'h0,               64'h1234_5678,          3, 2'b00, 64'h1234_5678,          32'h040, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 0, 3'b101, 32'h002, 64'h0,               64'h8001_0000,          1, 2'b00, 64'h0000_8001,          32'h000, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 0, 3'b001, 32'h002, 64'h0,               64'h8001_0000,          0, 2'b00, 64'hFFFF_8001,          32'h000, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 1, 3'b100, 32'h004, 64'h55,              64'h0,                  0, 2'b10, 64'h0,                  32'h004, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 0, 3'b111, 32'h001, 64'h0,               64'h0,                  0, 2'b10, 64'h0,                  32'h000, 64'h0,                 8'h00));
    vecs.push_back(mk(0, 1, 3'b010, 32'h004, 64'hDEAD_BEEF,       64'h0,                  2, 2'b00, 64'h0,                  32'h004, 64'hDEAD_BEEF,         8'h0F));
    vecs.push_back(mk(0, 1, 3'b000, 32'h007, 64'h1234_56A5,       64'h0,                  0, 2'b00, 64'h0,                  32'h004, 64'hA5A5_A5A5,         8'h08));
    vecs.push_back(mk(1, 0, 3'b110, 32'h014, 64'h0,               64'h8765_4321_0000_0000,0, 2'b00, 64'h0000_0000_8765_4321,32'h010, 64'h0,                 8'h00));
    vecs.push_back(mk(1, 1, 3'b011, 32'h008, 64'h0123_4567_89AB_CDEF, 64'h0,              1, 2'b00, 64'h0,                  32'h008, 64'h0123_4567_89AB_CDEF, 8'hFF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h004, 64'h0,               64'h8000_0000_0000_0000,0, 2'b00, 64'hFFFF_FFFF_8000_0000,32'h000, 64'h0,                 8'h00));
    vecs.push_back(mk(1, 1, 3'b000, 32'h005, 64'hA5,              64'h0,                  0, 2'b00, 64'h0,                  32'h000, 64'hA5A5_A5A5_A5A5_A5A5, 8'h20));
    vecs.push_back(mk(1, 0, 3'b011, 32'h004, 64'h0,               64'h0,                  0, 2'b01, 64'h0,                  32'h000, 64'h0,                 8'h00));
    vecs.push_back(mk(1, 0, 3'b000, 32'h009, 64'h0,               64'h0,                  6, 2'b11, 64'h0,                  32'h008, 64'h0,                 8'h00));
    vecs.push_back(mk(1, 0, 3'b011, 32'h010, 64'h0,               64'hFEDC_BA98_7654_3210,2, 2'b00, 64'hFEDC_BA98_7654_3210,32'h010, 64'h0,                 8'h00));
    vecs.push_back(mk(1, 0, 3'b111, 32'h000, 64'h0,               64'h0,                  0, 2'b10, 64'h0,                  32'h000, 64'h0,                 8'h00));

    // Reset state: every output of both units is 0, including req_ready.
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      check($sformatf("rst%0d req_ready", s),  64'(req_ready_o),  64'd0);
      check($sformatf("rst%0d mem_valid", s),  64'(mem_valid_o),  64'd0);
      check($sformatf("rst%0d resp_valid", s), 64'(resp_valid_o), 64'd0);
      check($sformatf("rst%0d resp_rdata", s), resp_rdata_o,      64'd0);
      check($sformatf("rst%0d resp_err", s),   64'(resp_err_o),   64'd0);
      check($sformatf("rst%0d mem_addr", s),   64'(mem_addr_o),   64'd0);
      check($sformatf("rst%0d mem_wstrb", s),  64'(mem_wstrb_o),  64'd0);
      check($sformatf("rst%0d state", s),      64'(dbg_o),        64'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_access($sformatf("vec%0d", i), vecs[i].is64, vecs[i].wr, vecs[i].f3,
                 vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].waits,
                 vecs[i].xerr, vecs[i].xrd, vecs[i].xaddr, vecs[i].xwd, vecs[i].xstrb);
    end

    // Reset asserted in the middle of a bus transfer.
    sel64 = 1'b0;
    #1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    check("midrst bus1", 64'(mem_valid_o), 64'd1);
    @(negedge clk);
    check("midrst bus2", 64'(mem_valid_o), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst mem_valid", 64'(mem_valid_o),  64'd0);
    check("midrst req_ready", 64'(req_ready_o),  64'd0);
    check("midrst resp",      64'(resp_valid_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst noresp%0d", c), 64'(resp_valid_o), 64'd0);
      check($sformatf("midrst state%0d", c),  64'(dbg_o),        64'd0);
    end
    resetn = 1'b1;
    run_access("post_rst_lbu", 1'b0, 1'b0, 3'b100, 32'h101, 64'h0, 64'h0000_9C00, 1,
               2'b00, 64'h9C, 32'h100, 64'h0, 8'h00);

    // Randomized accesses checked against the model.
    for (int n = 0; n < 80; n++) begin
      r64    = 1'($urandom_range(0, 1));
      rwr    = 1'($urandom_range(0, 1));
      rf3    = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 255));
      r_wd   = {$urandom, $urandom};
      r_rd   = {$urandom, $urandom};
      rwaits = $urandom_range(0, 3) == 0 ? $urandom_range(0, (r64 ? MW64 : MW32) + 1)
                                         : $urandom_range(0, 2);
      model(r64, rwr, rf3, r_addr, r_wd, r_rd, rwaits, m_err, m_rd, m_addr, m_wd, m_strb);
      run_access($sformatf("rnd%0d", n), r64, rwr, rf3, r_addr, r_wd, r_rd, rwaits,
                 m_err, m_rd, m_addr, m_wd, m_strb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck handshake still produces a summary.
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
